// File: rtl/tb_mem_scheduler.sv
// Survivor-memory scheduler for the Viterbi decoder: circular ACS write pointer plus
// periodic backwards traceback (TB_LEN trace reads followed by DEC_LEN decode reads).
module tb_mem_scheduler #(
   parameter  int MEM_DEPTH = 64,
   parameter  int TB_LEN    = 16,
   parameter  int DEC_LEN   = 8,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          i_en_acs,
   input  logic          i_sync,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr,
   output logic          o_rd_en,
   output logic [AW-1:0] o_rd_addr,
   output logic          o_tb_start,
   output logic          o_dec_valid,
   output logic          o_busy,
   output logic          o_overrun
);

   localparam int CW = $clog2(TB_LEN + DEC_LEN + 1);

   typedef enum logic [1:0] {IDLE, TRACE, DECODE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] phase_q, phase_d;
   logic          primed_q, primed_d;
   logic          pend_q, pend_d;
   logic [AW-1:0] pend_snap_q, pend_snap_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          dec_valid_q, dec_valid_d;
   logic          tb_start_q, tb_start_d;
   logic          overrun_q, overrun_d;

   logic          wr_acc;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] launch_target;
   logic          launch;
   logic [AW-1:0] snap;

   assign wr_acc        = en & i_en_acs;
   assign cnt_inc       = cnt_q + 1'b1;
   assign launch_target = primed_q ? CW'(DEC_LEN) : CW'(TB_LEN + DEC_LEN);
   assign launch        = wr_acc && (cnt_inc == launch_target) && !i_sync;
   assign snap          = wp_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      primed_d    = primed_q;
      pend_d      = pend_q;
      pend_snap_d = pend_snap_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      dec_valid_d = dec_valid_q;
      tb_start_d  = tb_start_q;
      overrun_d   = overrun_q;

      if (en) begin
         if (wr_acc) wp_d = wp_q + 1'b1;

         if (i_sync) begin
            cnt_d       = wr_acc ? CW'(1) : '0;
            primed_d    = 1'b0;
            pend_d      = 1'b0;
            state_d     = IDLE;
            phase_d     = '0;
            rd_en_d     = 1'b0;
            dec_valid_d = 1'b0;
            tb_start_d  = 1'b0;
         end else begin
            if (wr_acc) cnt_d = launch ? '0 : cnt_inc;
            if (launch) primed_d = 1'b1;
            tb_start_d = 1'b0;

            case (state_q)
               IDLE: begin
                  if (launch) begin
                     state_d     = TRACE;
                     phase_d     = '0;
                     rd_en_d     = 1'b1;
                     dec_valid_d = 1'b0;
                     tb_start_d  = 1'b1;
                     rd_addr_d   = snap - 1'b1;
                  end
               end
               TRACE: begin
                  rd_addr_d = rd_addr_q - 1'b1;
                  if (phase_q == CW'(TB_LEN - 1)) begin
                     state_d     = DECODE;
                     phase_d     = '0;
                     dec_valid_d = 1'b1;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
                  if (launch) begin
                     if (pend_q) begin
                        overrun_d = 1'b1;
                     end else begin
                        pend_d      = 1'b1;
                        pend_snap_d = snap;
                     end
                  end
               end
               DECODE: begin
                  // A launch on the final decode read chains straight into the next trace.
                  if (phase_q == CW'(DEC_LEN - 1)) begin
                     phase_d     = '0;
                     dec_valid_d = 1'b0;
                     if (pend_q || launch) begin
                        state_d    = TRACE;
                        rd_en_d    = 1'b1;
                        tb_start_d = 1'b1;
                        rd_addr_d  = (pend_q ? pend_snap_q : snap) - 1'b1;
                        pend_d     = 1'b0;
                        if (pend_q && launch) overrun_d = 1'b1;
                     end else begin
                        state_d = IDLE;
                        rd_en_d = 1'b0;
                     end
                  end else begin
                     rd_addr_d = rd_addr_q - 1'b1;
                     phase_d   = phase_q + 1'b1;
                     if (launch) begin
                        if (pend_q) begin
                           overrun_d = 1'b1;
                        end else begin
                           pend_d      = 1'b1;
                           pend_snap_d = snap;
                        end
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         cnt_q       <= '0;
         phase_q     <= '0;
         primed_q    <= 1'b0;
         pend_q      <= 1'b0;
         pend_snap_q <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         dec_valid_q <= 1'b0;
         tb_start_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         primed_q    <= primed_d;
         pend_q      <= pend_d;
         pend_snap_q <= pend_snap_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         dec_valid_q <= dec_valid_d;
         tb_start_q  <= tb_start_d;
         overrun_q   <= overrun_d;
      end
   end

   // Dropping en suppresses the pending read; it is reissued unchanged once en returns.
   assign o_wr_en     = wr_acc;
   assign o_wr_addr   = wp_q;
   assign o_rd_en     = rd_en_q & en;
   assign o_rd_addr   = rd_addr_q;
   assign o_tb_start  = tb_start_q & en;
   assign o_dec_valid = dec_valid_q & en;
   assign o_busy      = (state_q != IDLE);
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_tb_mem_scheduler.sv
// Directed bench for tb_mem_scheduler: fill, pending/overrun, wrap, sync abort,
// enable gating and asynchronous reset, all against hand-computed addresses.
module tb_tb_mem_scheduler;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          i_en_acs;
   logic          i_sync;
   logic          o_wr_en;
   logic [AW-1:0] o_wr_addr;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic          o_tb_start;
   logic          o_dec_valid;
   logic          o_busy;
   logic          o_overrun;

   int vectorCount = 0;
   int missCount   = 0;

   tb_mem_scheduler #(.MEM_DEPTH(64), .TB_LEN(16), .DEC_LEN(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .i_en_acs    (i_en_acs),
      .i_sync      (i_sync),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .o_tb_start  (o_tb_start),
      .o_dec_valid (o_dec_valid),
      .o_busy      (o_busy),
      .o_overrun   (o_overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      vectorCount++;
      if (got != exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change one step after the clock edge; outputs are sampled a step later.
   task automatic applyStimulus(input logic e, input logic a, input logic s);
      en       = e;
      i_en_acs = a;
      i_sync   = s;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst      = 1'b1;
      en       = 1'b0;
      i_en_acs = 1'b0;
      i_sync   = 1'b0;
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   task automatic fillWrites(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         nextCycle();
      end
   endtask

   initial begin
      $display("[TB] fill and first traceback");
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_rd_en", o_rd_en, 0);
      checkOutput("rst_wr_addr", o_wr_addr, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_overrun", o_overrun, 0);
      checkOutput("rst_tb_start", o_tb_start, 0);
      checkOutput("rst_dec_valid", o_dec_valid, 0);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput("fill_wr_en", o_wr_en, 1);
         checkOutput("fill_wr_addr", o_wr_addr, i);
         checkOutput("fill_no_rd", o_rd_en, 0);
         nextCycle();
      end
      for (int j = 0; j < 24; j++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("t1_rd_en", o_rd_en, 1);
         checkOutput("t1_rd_addr", o_rd_addr, 23 - j);
         checkOutput("t1_dec_valid", o_dec_valid, (j >= 16) ? 1 : 0);
         checkOutput("t1_tb_start", o_tb_start, (j == 0) ? 1 : 0);
         checkOutput("t1_busy", o_busy, 1);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_end_rd_en", o_rd_en, 0);
      checkOutput("t1_end_busy", o_busy, 0);
      checkOutput("t1_end_wr_en", o_wr_en, 0);

      $display("[TB] pending launch and overrun");
      doReset();
      for (int c = 1; c <= 50; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (c == 25) begin
            checkOutput("t2_start1", o_tb_start, 1);
            checkOutput("t2_addr25", o_rd_addr, 23);
         end
         if (c == 33) checkOutput("t2_ovr33", o_overrun, 0);
         if (c == 40) checkOutput("t2_ovr40", o_overrun, 0);
         if (c == 41) begin
            checkOutput("t2_ovr41", o_overrun, 1);
            checkOutput("t2_addr41", o_rd_addr, 7);
            checkOutput("t2_dv41", o_dec_valid, 1);
         end
         if (c == 48) begin
            checkOutput("t2_addr48", o_rd_addr, 0);
            checkOutput("t2_dv48", o_dec_valid, 1);
         end
         if (c == 49) begin
            checkOutput("t2_start2", o_tb_start, 1);
            checkOutput("t2_addr49", o_rd_addr, 31);
            checkOutput("t2_dv49", o_dec_valid, 0);
            checkOutput("t2_busy49", o_busy, 1);
         end
         if (c == 50) begin
            checkOutput("t2_addr50", o_rd_addr, 30);
            checkOutput("t2_start50", o_tb_start, 0);
         end
         nextCycle();
      end

      $display("[TB] address wrap");
      doReset();
      for (int c = 1; c <= 43; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         checkOutput("t3_sync_rd_en", o_rd_en, 0);
         nextCycle();
      end
      for (int c = 44; c <= 66; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (c == 64) checkOutput("t3_wr63", o_wr_addr, 63);
         if (c == 65) checkOutput("t3_wr0", o_wr_addr, 0);
         if (c == 66) begin
            checkOutput("t3_wr1", o_wr_addr, 1);
            checkOutput("t3_rd_en66", o_rd_en, 0);
         end
         nextCycle();
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("t3_rd_addr", o_rd_addr, (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 63 : 62);
         checkOutput("t3_tb_start", o_tb_start, (k == 0) ? 1 : 0);
         checkOutput("t3_rd_en", o_rd_en, 1);
         nextCycle();
      end

      $display("[TB] sync during trace");
      doReset();
      fillWrites(24);
      for (int c = 25; c <= 28; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("t4_rd_en29", o_rd_en, 1);
      checkOutput("t4_addr29", o_rd_addr, 19);
      nextCycle();
      for (int c = 30; c <= 53; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput("t4_idle_rd_en", o_rd_en, 0);
         checkOutput("t4_idle_busy", o_busy, 0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t4_restart", o_tb_start, 1);
      checkOutput("t4_restart_addr", o_rd_addr, 47);

      $display("[TB] enable gating");
      doReset();
      fillWrites(24);
      for (int c = 25; c <= 42; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         nextCycle();
      end
      for (int c = 43; c <= 45; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput("t5_gate_rd_en", o_rd_en, 0);
         checkOutput("t5_gate_wr_en", o_wr_en, 0);
         checkOutput("t5_gate_dv", o_dec_valid, 0);
         checkOutput("t5_gate_addr", o_rd_addr, 5);
         checkOutput("t5_gate_busy", o_busy, 1);
         nextCycle();
      end
      for (int c = 46; c <= 51; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("t5_res_rd_en", o_rd_en, 1);
         checkOutput("t5_res_addr", o_rd_addr, 51 - c);
         checkOutput("t5_res_dv", o_dec_valid, 1);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_end_rd_en", o_rd_en, 0);
      checkOutput("t5_end_busy", o_busy, 0);

      $display("[TB] asynchronous reset during decode");
      doReset();
      fillWrites(24);
      for (int c = 25; c <= 42; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t6_pre_addr", o_rd_addr, 5);
      checkOutput("t6_pre_wr_addr", o_wr_addr, 24);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_rd_en", o_rd_en, 0);
      checkOutput("t6_rd_addr", o_rd_addr, 0);
      checkOutput("t6_dv", o_dec_valid, 0);
      checkOutput("t6_busy", o_busy, 0);
      checkOutput("t6_wr_addr", o_wr_addr, 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t6_post_wr_addr", o_wr_addr, 0);
      checkOutput("t6_post_wr_en", o_wr_en, 1);
      checkOutput("t6_post_rd_en", o_rd_en, 0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t6_post_wr_addr1", o_wr_addr, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
